// File: rtl/pll_5m_pkg.sv
// Shared defaults, widths and the lock-sequencer state encoding for the 5 MHz clock generator.
package pll_5m_pkg;

   localparam int ODIV_DEFAULT        = 10;
   localparam int LOCK_CYCLES_DEFAULT = 1024;
   localparam int LOCK_CNT_W          = 16;

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_LOCKED  = 1'b1
   } lock_state_e;

   // A half-period of one input cycle still needs a 1-bit counter register.
   function automatic int div_cnt_width(input int half);
      return (half < 2) ? 1 : $clog2(half);
   endfunction

endpackage

// File: rtl/pll_5m_div.sv
// Output divider: toggles clk_out every HALF enabled input edges, cleared while disabled or in reset.
module pll_5m_div
   import pll_5m_pkg::*;
#(
   parameter int HALF = ODIV_DEFAULT / 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic clk_out
);

   localparam int          CW   = div_cnt_width(HALF);
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_out_q, clk_out_d;

   always_comb begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      if (!en) begin
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_d     = '0;
         clk_out_d = ~clk_out_q;
      end else begin
         cnt_d     = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign clk_out = clk_out_q;

endmodule

// File: rtl/pll_5m.sv
// Clock generator: counts a fixed settle time after reset/power-down release, then runs the divider.
//
// state      | meaning
// ST_ACQUIRE | counting clkin1 edges towards lock, pll_lock low, divider held
// ST_LOCKED  | lock counter saturated, pll_lock high, divider running
module pll_5m
   import pll_5m_pkg::*;
#(
   parameter int ODIV        = ODIV_DEFAULT,
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
   input  logic clkin1,
   input  logic pll_rst,
   input  logic pll_pwd,
   output logic clkout0,
   output logic pll_lock
);

   localparam logic [LOCK_CNT_W-1:0] LOCK_TC = LOCK_CNT_W'(LOCK_CYCLES - 1);

   logic                  rst_any;
   lock_state_e           state_q, state_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic                  pll_lock_q, pll_lock_d;

   // Power-down and reset are indistinguishable to the lock and divider logic.
   assign rst_any = pll_rst | pll_pwd;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      pll_lock_d = pll_lock_q;
      case (state_q)
         ST_ACQUIRE: begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            if (lock_cnt_q == LOCK_TC) begin
               state_d    = ST_LOCKED;
               pll_lock_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            pll_lock_d = 1'b1;
         end
         default: begin
            state_d    = ST_ACQUIRE;
            lock_cnt_d = '0;
            pll_lock_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkin1) begin
      if (rst_any) begin
         state_q    <= ST_ACQUIRE;
         lock_cnt_q <= '0;
         pll_lock_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         pll_lock_q <= pll_lock_d;
      end
   end

   // Divider sees the registered lock, so the first output rise lands ODIV/2 edges after lock.
   pll_5m_div #(
      .HALF (ODIV / 2)
   ) u_div (
      .clk     (clkin1),
      .rst     (rst_any),
      .en      (pll_lock_q),
      .clk_out (clkout0)
   );

   assign pll_lock = pll_lock_q;

endmodule

// File: tb/tb_pll_5m.sv
// Event scoreboard bench: expected lock/clock transitions are queued with their edge numbers.
module tb_pll_5m;

   typedef struct {
      int dut;
      int kind;
      int cyc;
   } ev_t;

   logic clkin1 = 1'b0;
   logic rst0, pwd0, rst1, pwd1;
   logic clk0, lock0, clk1, lock1;
   logic p_l0 = 1'b0, p_c0 = 1'b0, p_l1 = 1'b0, p_c1 = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   ev_t  exp_q[$];

   pll_5m #(.ODIV(10), .LOCK_CYCLES(1024)) u_dut0 (
      .clkin1   (clkin1),
      .pll_rst  (rst0),
      .pll_pwd  (pwd0),
      .clkout0  (clk0),
      .pll_lock (lock0)
   );

   pll_5m #(.ODIV(4), .LOCK_CYCLES(2)) u_dut1 (
      .clkin1   (clkin1),
      .pll_rst  (rst1),
      .pll_pwd  (pwd1),
      .clkout0  (clk1),
      .pll_lock (lock1)
   );

   always #10 clkin1 = ~clkin1;

   always @(posedge clkin1) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         0:       return "lock_rise";
         1:       return "lock_fall";
         2:       return "clk_rise";
         3:       return "clk_fall";
         default: return "unknown";
      endcase
   endfunction

   task automatic push(input int dut, input int kind, input int c);
      ev_t e;
      e.dut  = dut;
      e.kind = kind;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic seen(input int dut, input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got dut%0d %s at edge %0d, expected no event",
                  dut, kname(kind), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.dut != dut || e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got dut%0d %s at edge %0d, expected dut%0d %s at edge %0d",
                     dut, kname(kind), cyc, e.dut, kname(e.kind), e.cyc);
         end
      end
   endtask

   always @(negedge clkin1) begin
      if (mon_en) begin
         if (lock0 !== p_l0) seen(0, (lock0 === 1'b1) ? 0 : 1);
         if (clk0  !== p_c0) seen(0, (clk0  === 1'b1) ? 2 : 3);
         if (lock1 !== p_l1) seen(1, (lock1 === 1'b1) ? 0 : 1);
         if (clk1  !== p_c1) seen(1, (clk1  === 1'b1) ? 2 : 3);
      end
      p_l0 <= lock0;
      p_c0 <= clk0;
      p_l1 <= lock1;
      p_c1 <= clk1;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at edge %0d", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int t);
      if (cyc > t) begin
         checks++;
         errors++;
         $display("FAIL schedule: at edge %0d, expected to be at or before edge %0d", cyc, t);
      end
      while (cyc < t) @(negedge clkin1);
   endtask

   task automatic drive(input int dut, input logic r, input logic p);
      if (dut == 0) begin
         rst0 = r;
         pwd0 = p;
      end else begin
         rst1 = r;
         pwd1 = p;
      end
   endtask

   // n_rel is the last edge that sampled reset high; mode bit0 = pll_rst, bit1 = pll_pwd.
   // The interrupting reset lands mid high phase of the (periods+1)-th output pulse.
   task automatic phase(input int dut, input int half, input int lockc, input int n_rel,
                        input int periods, input int mode, input int hold, output int n_next);
      int r;
      int p;
      push(dut, 0, n_rel + lockc);
      for (int k = 0; k < periods; k++) begin
         r = n_rel + lockc + half + 2 * half * k;
         push(dut, 2, r);
         push(dut, 3, r + half);
      end
      r = n_rel + lockc + half + 2 * half * periods;
      push(dut, 2, r);
      p = r + half / 2;
      wait_cyc(p - 1);
      drive(dut, mode[0], mode[1]);
      push(dut, 1, p);
      push(dut, 3, p);
      n_next = p + hold - 1;
      if (hold > 0) begin
         wait_cyc(n_next);
         drive(dut, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int n;
      rst0 = 1'b1; pwd0 = 1'b0;
      rst1 = 1'b1; pwd1 = 1'b0;

      wait_cyc(1);
      chk("reset_lock0", lock0, 1'b0);
      chk("reset_clk0",  clk0,  1'b0);
      chk("reset_lock1", lock1, 1'b0);
      chk("reset_clk1",  clk1,  1'b0);
      mon_en = 1'b1;

      wait_cyc(2);
      chk("reset2_lock0", lock0, 1'b0);
      chk("reset2_clk0",  clk0,  1'b0);
      drive(0, 1'b0, 1'b0);
      n = 2;

      // ODIV=10, LOCK_CYCLES=1024: rst pulse, pwd for 10 edges, both together, then parked in reset.
      phase(0, 5, 1024, n, 60, 1, 1,  n);
      phase(0, 5, 1024, n, 20, 2, 10, n);
      phase(0, 5, 1024, n, 20, 3, 3,  n);
      phase(0, 5, 1024, n, 10, 1, 0,  n);

      // ODIV=4, LOCK_CYCLES=2.
      n = cyc;
      drive(1, 1'b0, 1'b0);
      phase(1, 2, 2, n, 30, 1, 1,  n);
      phase(1, 2, 2, n, 30, 2, 10, n);
      phase(1, 2, 2, n, 30, 3, 0,  n);

      wait_cyc(cyc + 10);
      chk("parked_lock0", lock0, 1'b0);
      chk("parked_clk0",  clk0,  1'b0);
      chk("parked_lock1", lock1, 1'b0);
      chk("parked_clk1",  clk1,  1'b0);

      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got nothing, expected dut%0d %s at edge %0d",
                  e.dut, kname(e.kind), e.cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
